div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the DIV/DIVU instructions. Sits directly downstream of the register file: `rdata1` feeds the dividend and `rdata2` feeds the divisor. The quotient and remainder are delivered to the HI/LO write path. It uses restoring division at one quotient bit per cycle, has a fixed latency, and provides a `busy` signal so the controller can stall the PC and instruction fetch.

## Interface
- `WIDTH`, default 32: operand width; iteration count equals `WIDTH`.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `sign` in 1: 1 = DIV (two's complement), 0 = DIVU; captured with `start`.
- `dividend` in WIDTH: captured with `start`.
- `divisor` in WIDTH: captured with `start`.
- `q` out WIDTH: quotient (to LO); registered; held until the next accepted `start` or reset.
- `r` out WIDTH: remainder (to HI); registered; held the same way as `q`.
- `busy` out 1: high in CALC and FIN.
- `done` out 1: one-cycle pulse in FIN; `q`/`r` are valid from this cycle.

## Operation
- **States:**
  - IDLE→CALC on `start`.
  - CALC→FIN after `WIDTH` iterations.
  - FIN→IDLE unconditionally.
- **Capture in IDLE with `start`=1:**
  - Store the magnitudes of both operands. In signed mode a negative operand is two's-complement negated; `0x80000000` stays `0x80000000`, read as unsigned.
  - Store `negq` = `sign` & (`dividend`[31] ^ `divisor`[31]).
  - Store `negr` = `sign` & `dividend`[31].
  - Store `dz` = (`divisor` == 0).
  - Clear the remainder accumulator (WIDTH+1 bits) and the iteration counter.
- **CALC iteration (once per cycle):**
  - Shift the pair {remainder, quotient} left by 1.
  - trial = shifted remainder − {0, divisor magnitude}.
  - No borrow: remainder = trial, quotient LSB = 1.
  - Borrow: keep the shifted remainder, quotient LSB = 0.
- **Final CALC edge (iteration `WIDTH`):**
  - `q` loads the quotient, negated if `negq`.
  - `r` loads the remainder, negated if `negr`.
  - If `dz`, `q` = all ones and `r` = the original dividend, regardless of `sign`.
- **Signed overflow:** `0x80000000` / −1 gives `q`=`0x80000000`, `r`=0. No trap.
- `start` in CALC or FIN is ignored; no queueing.
- Operand inputs may change after capture without effect.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `q`=0, `r`=0.
  - Internal working registers 0.
- Reset mid-CALC or in FIN aborts the operation: next cycle IDLE, `done` never pulses, `q`=`r`=0.
- If `start` is high in cycle c0 (IDLE):
  - `busy`=1 in cycles c1..c(`WIDTH`+1).
  - CALC occupies c1..c`WIDTH`.
  - FIN is c(`WIDTH`+1); with the default width this is c33.
  - `done`=1 in c33 only; `busy` drops in c34.
- Latency is fixed at `WIDTH`+1 cycles, including divide-by-zero.
- Back-to-back operation: the earliest next `start` is sampled in c34 (IDLE), giving a 34-cycle issue interval.
- `done` and `busy` are registered state decodes; there is no combinational path from inputs to outputs.

## Structure
- Shared CPU package `cpu_pkg` holds:
  - The state encodings DIV_IDLE, DIV_CALC, DIV_FIN.
  - DIV_WIDTH=32.
  - The iteration-counter width $clog2(DIV_WIDTH)+1.
- One sub-module, `div_step`: purely combinational single restoring iteration.
  - Inputs: remainder, quotient, divisor magnitude.
  - Outputs: next remainder, next quotient.
  - Lets the bench unit-test the step in isolation.
- Sign handling, FSM, counter and output registers stay in `div_unit`.

## Test plan
- DIVU 7/2, `start` in c0 → `busy` high c1–c33, `done` only in c33, `q`=3, `r`=1; values hold through c40.
- DIV −7/2 (`0xFFFFFFF9`, 2) → `q`=`0xFFFFFFFD`, `r`=`0xFFFFFFFF`. DIV 7/−2 → `q`=`0xFFFFFFFD`, `r`=1.
- DIV `0x80000000`/`0xFFFFFFFF` → `q`=`0x80000000`, `r`=0. DIVU `0xFFFFFFFF`/`0x10` → `q`=`0x0FFFFFFF`, `r`=`0xF`.
- DIVU 100/0 and DIV −5/0 → `done` in c33; `q`=`0xFFFFFFFF`, `r`=100 and `r`=`0xFFFFFFFB` respectively.
- Pulse `start` with new operands in c10 and c33 during a busy operation → ignored; first result unchanged; a new `start` in c34 is accepted, with `done` in c67.
- Assert `rst` in c15 of an operation → c16 in IDLE, `busy`=`done`=0, `q`=`r`=0, no `done` pulse at c33; a fresh 9/3 then gives `q`=3, `r`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encoding, default operand width and
// iteration-counter width.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {remainder, quotient} left by one,
// subtract the divisor magnitude when it fits and record the quotient bit.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // The extra top bit keeps the comparison exact even if the accumulator MSB is set.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign fits    = (shifted >= {2'b00, dvs_i});
  assign trial   = shifted[WIDTH:0] - {1'b0, dvs_i};

  assign rem_o = fits ? trial : shifted[WIDTH:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned integer divider, one quotient bit per cycle,
// fixed latency of WIDTH+1 cycles from an accepted start to done.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_CALC;
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          dvd_d   = dividend;
          negq_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = sign & dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          cnt_d   = '0;
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DIV_FIN;
          // Divide-by-zero returns all ones and the untouched dividend in either mode.
          if (dz_q) begin
            q_d = '1;
            r_d = dvd_q;
          end else begin
            q_d = negq_q ? -step_quo : step_quo;
            r_d = negr_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
          end
        end
      end
      DIV_FIN: state_d = DIV_IDLE;
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q != DIV_IDLE);
  assign done = (state_q == DIV_FIN);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit and div_step against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] q, r;
  logic        busy, done;

  logic [32:0] st_rem_i, st_rem_o;
  logic [31:0] st_quo_i, st_quo_o, st_dvs_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done)
  );

  div_step #(.WIDTH(32)) u_step_tb (
    .rem_i (st_rem_i),
    .quo_i (st_quo_i),
    .dvs_i (st_dvs_i),
    .rem_o (st_rem_o),
    .quo_o (st_quo_o)
  );

  // Reference: 64-bit integer division truncates toward zero, matching DIV/DIVU.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] qe, output logic [31:0] re);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      qe = 32'hFFFF_FFFF;
      re = a;
      return;
    end
    la = s ? longint'($signed(a)) : longint'(a);
    lb = s ? longint'($signed(b)) : longint'(b);
    lq = la / lb;
    lr = la % lb;
    qe = lq[31:0];
    re = lr[31:0];
  endfunction

  // Called at a falling edge; issues start in that cycle (c0) and returns at the falling edge of c34.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat, output logic [31:0] qo, output logic [31:0] ro,
                        output int busy_bad);
    lat = -1;
    qo = '0;
    ro = '0;
    busy_bad = 0;
    dividend = a;
    divisor = b;
    sign = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    sign = 1'($urandom_range(0, 1));
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (busy !== 1'(n <= 33)) busy_bad++;
      if (done === 1'b1) begin
        if (lat < 0) begin
          lat = n;
          qo = q;
          ro = r;
        end else begin
          busy_bad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (q !== 32'd0) begin errors++; $display("FAIL reset_q: got %h expected 0", q); end
    if (r !== 32'd0) begin errors++; $display("FAIL reset_r: got %h expected 0", r); end
    rst = 1'b0;
    $display("reset: busy=%b done=%b q=%h r=%h", busy, done, q, r);
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFB};
    logic [31:0] tb [7] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h10, 32'd0, 32'd0};
    logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] tq [7] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tr [7] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hF, 32'd100, 32'hFFFF_FFFB};
    int lat, bb, hold_bad;
    logic [31:0] qo, ro;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, qo, ro, bb);
      checks += 4;
      if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
      if (bb != 0) begin errors++; $display("FAIL dir%0d_busy_done: got %0d bad cycles expected 0", i, bb); end
      if (qo !== tq[i]) begin errors++; $display("FAIL dir%0d_q: got %h expected %h", i, qo, tq[i]); end
      if (ro !== tr[i]) begin errors++; $display("FAIL dir%0d_r: got %h expected %h", i, ro, tr[i]); end
      $display("directed %0d: %h / %h sign=%b -> q=%h r=%h lat=%0d", i, ta[i], tb[i], ts[i], qo, ro, lat);
      if (i == 0) begin
        hold_bad = 0;
        for (int n = 35; n <= 40; n++) begin
          @(negedge clk);
          if (q !== 32'd3 || r !== 32'd1 || done !== 1'b0 || busy !== 1'b0) hold_bad++;
        end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL hold_c40: got %0d bad cycles expected 0", hold_bad); end
      end
    end
  endtask

  task automatic test_random();
    int lat, bb;
    logic [31:0] a, b, qo, ro, qe, re;
    logic s;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        3, 4:    b = -$urandom_range(1, 255);
        5:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(a, b, s, qe, re);
      run_op(a, b, s, lat, qo, ro, bb);
      checks += 3;
      if (lat != 33 || bb != 0) begin errors++; $display("FAIL rnd%0d_timing: got lat=%0d bad=%0d expected 33/0", i, lat, bb); end
      if (qo !== qe) begin errors++; $display("FAIL rnd%0d_q: %h/%h s=%b got %h expected %h", i, a, b, s, qo, qe); end
      if (ro !== re) begin errors++; $display("FAIL rnd%0d_r: %h/%h s=%b got %h expected %h", i, a, b, s, ro, re); end
      $display("random %0d: %h / %h sign=%b -> q=%h r=%h", i, a, b, s, qo, ro);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb, done_at;
    logic [31:0] qo, ro, q1, r1;
    done_at = -1;
    q1 = '0;
    r1 = '0;
    bb = 0;
    dividend = 32'd1000;
    divisor = 32'd7;
    sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (done_at < 0) begin done_at = n; q1 = q; r1 = r; end else bb++;
      end
      if (busy !== 1'(n <= 33)) bb++;
      start = 1'b0;
      if (n == 10 || n == 33) begin
        dividend = 32'd12345;
        divisor = 32'd3;
        sign = 1'b1;
        start = 1'b1;
      end
    end
    checks += 3;
    if (done_at != 33 || bb != 0) begin errors++; $display("FAIL b2b_first_timing: got done_at=%0d bad=%0d expected 33/0", done_at, bb); end
    if (q1 !== 32'd142) begin errors++; $display("FAIL b2b_first_q: got %h expected %h", q1, 32'd142); end
    if (r1 !== 32'd6) begin errors++; $display("FAIL b2b_first_r: got %h expected %h", r1, 32'd6); end
    $display("back_to_back first: 1000/7 -> q=%h r=%h done_at=%0d", q1, r1, done_at);
    // Issued in c34, so done must land in c67.
    run_op(32'hFFFF_FF9C, 32'd9, 1'b1, lat, qo, ro, bb);
    checks += 3;
    if (lat != 33 || bb != 0) begin errors++; $display("FAIL b2b_second_timing: got lat=%0d bad=%0d expected 33/0", lat, bb); end
    if (qo !== 32'hFFFF_FFF5) begin errors++; $display("FAIL b2b_second_q: got %h expected fffffff5", qo); end
    if (ro !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_r: got %h expected ffffffff", ro); end
    $display("back_to_back second: -100/9 -> q=%h r=%h done at c%0d", qo, ro, 34 + lat);
  endtask

  task automatic test_reset_midop();
    int lat, bb, late_bad;
    logic [31:0] qo, ro;
    late_bad = 0;
    dividend = 32'd500;
    divisor = 32'd3;
    sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 15) rst = 1'b1;
      if (n == 16) begin
        rst = 1'b0;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        if (q !== 32'd0) begin errors++; $display("FAIL midrst_q: got %h expected 0", q); end
        if (r !== 32'd0) begin errors++; $display("FAIL midrst_r: got %h expected 0", r); end
      end
      if (n > 16 && (done !== 1'b0 || busy !== 1'b0)) late_bad++;
    end
    checks++;
    if (late_bad != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", late_bad); end
    run_op(32'd9, 32'd3, 1'b0, lat, qo, ro, bb);
    checks += 3;
    if (lat != 33 || bb != 0) begin errors++; $display("FAIL midrst_next_timing: got lat=%0d bad=%0d expected 33/0", lat, bb); end
    if (qo !== 32'd3) begin errors++; $display("FAIL midrst_next_q: got %h expected 3", qo); end
    if (ro !== 32'd0) begin errors++; $display("FAIL midrst_next_r: got %h expected 0", ro); end
    $display("reset_midop: aborted, then 9/3 -> q=%h r=%h", qo, ro);
  endtask

  task automatic test_step();
    longint sh, rexp;
    logic bit_e;
    logic [32:0] rem_e;
    logic [31:0] quo_e;
    for (int i = 0; i < 32; i++) begin
      st_dvs_i = (i < 8) ? $urandom_range(1, 15) : ($urandom | 32'h1);
      st_rem_i = {1'b0, $urandom % st_dvs_i};
      st_quo_i = $urandom;
      sh = longint'(st_rem_i) * 2 + longint'(st_quo_i[31]);
      bit_e = (sh >= longint'(st_dvs_i));
      rexp = bit_e ? sh - longint'(st_dvs_i) : sh;
      rem_e = rexp[32:0];
      quo_e = {st_quo_i[30:0], bit_e};
      #1;
      checks += 2;
      if (st_rem_o !== rem_e) begin errors++; $display("FAIL step%0d_rem: got %h expected %h", i, st_rem_o, rem_e); end
      if (st_quo_o !== quo_e) begin errors++; $display("FAIL step%0d_quo: got %h expected %h", i, st_quo_o, quo_e); end
      $display("step %0d: rem=%h quo=%h dvs=%h -> rem=%h quo=%h", i, st_rem_i, st_quo_i, st_dvs_i, st_rem_o, st_quo_o);
    end
  endtask

  initial begin
    st_rem_i = '0;
    st_quo_i = '0;
    st_dvs_i = 32'd1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
